// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and divisor rules.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam logic [15:0] MIN_DIVISOR = 16'd4;

    // Below four clocks per bit the mid-bit sample would land outside the bit.
    function automatic logic [15:0] clamp_divisor(input logic [15:0] div);
        return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit; reset loads RESET_VAL into every stage.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: non-blocking assignments make each stage take the previous stage's old value,
    // giving a true shift chain rather than collapsing it into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronises rxd, samples mid-bit with a latched divisor,
// and reports each byte with a one-cycle strobe or a framing-error pulse.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic [15:0] clkdiv,
    output logic [7:0]  rxdata,
    output logic        rxstb,
    output logic        framing_err,
    output logic        busy
);

    logic        rxs;
    uart_state_e state_q;
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rxdata_q;
    logic        rxstb_q;
    logic        ferr_q;
    logic        busy_q;
    logic        cnt_zero;

    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    assign div_d    = clamp_divisor(clkdiv);
    assign cnt_zero = (cnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= 16'd0;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            rxdata_q  <= 8'h00;
            rxstb_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each one is exactly one clock wide.
            rxstb_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        div_q   <= div_d;
                        cnt_q   <= div_d >> 1;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (rxs) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= div_q - 16'd1;
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shift_q <= {rxs, shift_q[7:1]};
                        cnt_q   <= div_q - 16'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (rxs) begin
                        rxdata_q <= shift_q;
                        rxstb_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    // A held-low line is not a new start bit; wait for the line to recover.
                    if (rxs) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rxdata      = rxdata_q;
    assign rxstb       = rxstb_q;
    assign framing_err = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: frame-level reference model predicting strobe/error times,
// rxdata and busy windows from the bit-timing rules, compared every cycle.
module tb_uart_rx_deser;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] clkdiv = 16'd16;
    logic [7:0]  rxdata;
    logic        rxstb;
    logic        framing_err;
    logic        busy;

    uart_rx_deser #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .clkdiv      (clkdiv),
        .rxdata      (rxdata),
        .rxstb       (rxstb),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned edge_n = 0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) edge_n++;

    typedef enum {EV_STB, EV_FERR, EV_RST} ev_kind_e;
    typedef struct {
        int unsigned at;
        ev_kind_e    kind;
        logic [7:0]  data;
    } ev_t;
    typedef struct {
        int unsigned lo;
        int unsigned hi;
    } span_t;

    ev_t        ev_q[$];
    span_t      span_q[$];
    logic [7:0] model_rxdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Per-cycle comparison against the frame-level model.
    always @(negedge clk) begin
        bit exp_stb;
        bit exp_ferr;
        bit exp_busy;
        if (cmp_en) begin
            exp_stb  = 1'b0;
            exp_ferr = 1'b0;
            if (ev_q.size() != 0 && ev_q[0].at == edge_n) begin
                case (ev_q[0].kind)
                    EV_STB:  begin exp_stb = 1'b1; model_rxdata = ev_q[0].data; end
                    EV_FERR: exp_ferr = 1'b1;
                    default: model_rxdata = 8'h00;
                endcase
                void'(ev_q.pop_front());
            end
            while (span_q.size() != 0 && span_q[0].hi <= edge_n) void'(span_q.pop_front());
            exp_busy = (span_q.size() != 0) && (span_q[0].lo <= edge_n);
            check("outputs{busy,stb,ferr,rxdata}", {busy, rxstb, framing_err, rxdata},
                  {exp_busy, exp_stb, exp_ferr, model_rxdata});
        end
    end

    int unsigned stb_cnt = 0;
    int unsigned ferr_cnt = 0;
    int unsigned last_stb_edge = 0;
    logic [7:0]  last_stb_data = 8'h00;
    logic [7:0]  got_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rxstb) begin
                stb_cnt++;
                last_stb_edge = edge_n;
                last_stb_data = rxdata;
                got_q.push_back(rxdata);
            end
            if (framing_err) ferr_cnt++;
        end
    end

    function automatic int unsigned eff_div(input logic [15:0] div);
        return (div < 16'd4) ? 4 : int'(div);
    endfunction

    task automatic idle(input int cycles);
        rxd = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one frame from a negedge. stop_low>0 holds the stop bit low that long;
    // new_div is applied to clkdiv during bit 3; abort_bit>=0 pulses reset mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic [15:0] div, input int stop_low,
                              input logic [15:0] new_div, input int abort_bit);
        int unsigned d;
        int unsigned f;
        int unsigned stop_edge;
        d = eff_div(div);
        clkdiv = div;
        f = edge_n;
        rxd = 1'b0;
        stop_edge = f + SYNC + 1 + d / 2 + 1 + 9 * d;
        span_q.push_back('{lo: f + SYNC + 1, hi: (stop_low > 0) ? 32'hFFFF_FFFF : stop_edge});
        ev_q.push_back('{at: stop_edge, kind: (stop_low > 0) ? EV_FERR : EV_STB, data: b});
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) clkdiv = new_div;
            rxd = b[i];
            if (i == abort_bit) begin
                repeat (d / 2) @(negedge clk);
                reset = 1'b1;
                rxd = 1'b1;
                void'(ev_q.pop_back());
                ev_q.push_back('{at: edge_n + 1, kind: EV_RST, data: 8'h00});
                span_q[span_q.size() - 1].hi = edge_n + 1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            repeat (d) @(negedge clk);
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            repeat (stop_low) @(negedge clk);
            rxd = 1'b1;
            span_q[span_q.size() - 1].hi = edge_n + SYNC + 1;
            repeat (d) @(negedge clk);
        end else begin
            rxd = 1'b1;
            repeat (d) @(negedge clk);
        end
    endtask

    // Low pulse shorter than the start-bit sample point: receiver must drop back to idle.
    task automatic glitch(input int g, input logic [15:0] div);
        int unsigned d;
        int unsigned f;
        d = eff_div(div);
        clkdiv = div;
        f = edge_n;
        rxd = 1'b0;
        span_q.push_back('{lo: f + SYNC + 1, hi: f + SYNC + 1 + d / 2 + 1});
        repeat (g) @(negedge clk);
        rxd = 1'b1;
        repeat (d) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: actual running required finished");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int unsigned f0;
        int unsigned sb;
        int unsigned fb;
        int unsigned gb;
        logic [7:0]  v;
        logic [7:0]  exp031 [3];
        logic [15:0] div;
        int unsigned d;
        int          sel;
        exp031 = '{8'h00, 8'hFF, 8'hA3};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_state", {busy, rxstb, framing_err, rxdata}, 32'h0);
        reset = 1'b0;
        idle(4);

        // 0x55 at 16 clocks/bit: single strobe at the predicted latency
        sb = stb_cnt;
        f0 = edge_n;
        send_frame(8'h55, 16'd16, 0, 16'd16, -1);
        idle(4);
        check("r030_count", stb_cnt - sb, 1);
        check("r030_data", last_stb_data, 8'h55);
        check("r030_latency", last_stb_edge - f0, 156);

        // back-to-back frames
        sb = stb_cnt;
        fb = ferr_cnt;
        gb = got_q.size();
        send_frame(8'h00, 16'd16, 0, 16'd16, -1);
        send_frame(8'hFF, 16'd16, 0, 16'd16, -1);
        send_frame(8'hA3, 16'd16, 0, 16'd16, -1);
        idle(4);
        check("r031_count", stb_cnt - sb, 3);
        check("r031_ferr", ferr_cnt - fb, 0);
        for (int i = 0; i < 3; i++) begin
            v = 8'hxx;
            if (got_q.size() > gb + i) v = got_q[gb + i];
            check("r031_data", v, exp031[i]);
        end

        // 5-cycle glitch
        sb = stb_cnt;
        glitch(5, 16'd16);
        idle(4);
        check("r032_no_stb", stb_cnt - sb, 0);
        check("r032_idle", busy, 1'b0);

        // stop bit held low, then a good frame
        sb = stb_cnt;
        fb = ferr_cnt;
        send_frame(8'h3C, 16'd16, 40, 16'd16, -1);
        check("r033_ferr", ferr_cnt - fb, 1);
        check("r033_no_stb", stb_cnt - sb, 0);
        check("r033_rxdata_kept", rxdata, 8'hA3);
        send_frame(8'h81, 16'd16, 0, 16'd16, -1);
        idle(4);
        check("r033_next", last_stb_data, 8'h81);

        // clamped divisor and mid-frame divisor change
        send_frame(8'h5A, 16'd2, 0, 16'd2, -1);
        idle(4);
        check("r034_clamp", last_stb_data, 8'h5A);
        f0 = edge_n;
        send_frame(8'hE7, 16'd16, 0, 16'd32, -1);
        idle(4);
        check("r034_latched", last_stb_data, 8'hE7);
        check("r034_latency", last_stb_edge - f0, 156);

        // reset in the middle of data bit 4
        sb = stb_cnt;
        fb = ferr_cnt;
        send_frame(8'h96, 16'd16, 0, 16'd16, 4);
        idle(8);
        check("r035_no_stb", stb_cnt - sb, 0);
        check("r035_no_ferr", ferr_cnt - fb, 0);
        check("r035_reset_vals", {busy, rxdata}, 9'h000);
        send_frame(8'hC3, 16'd16, 0, 16'd16, -1);
        idle(4);
        check("r035_next", last_stb_data, 8'hC3);

        // randomized traffic
        for (int k = 0; k < 150; k++) begin
            div = 16'($urandom_range(0, 24));
            d = eff_div(div);
            sel = int'($urandom_range(0, 99));
            if (sel < 10) begin
                glitch(int'($urandom_range(1, d / 2 + 1)), div);
            end else if (sel < 20) begin
                send_frame(8'($urandom), div, int'($urandom_range(d / 2 + 2, 3 * d)), div, -1);
            end else if (sel < 25) begin
                send_frame(8'($urandom), div, 0, div, int'($urandom_range(0, 7)));
                idle(4);
            end else if (sel < 40) begin
                send_frame(8'($urandom), div, 0, 16'($urandom_range(0, 40)), -1);
            end else begin
                send_frame(8'($urandom), div, 0, div, -1);
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 5)));
        end

        idle(20);
        check("events_drained", ev_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
